// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared widths, defaults and hit-word layout for the TDC hit buffer
package tdc_pkg;

  localparam int HIT_W          = 44;
  localparam int BCID_W         = 12;
  localparam int BC_MAX_DEFAULT = 3563;

  localparam int TOT_W = 9;
  localparam int TOA_W = 10;
  localparam int CAL_W = 10;

  // Bit offsets of each field inside the 44-bit hit word (LSB first)
  localparam int TOT_LSB     = 0;
  localparam int TOA_LSB     = 9;
  localparam int CAL_LSB     = 19;
  localparam int TOT_ERR_BIT = 29;
  localparam int TOA_ERR_BIT = 30;
  localparam int CAL_ERR_BIT = 31;
  localparam int BCID_LSB    = 32;

  typedef logic [HIT_W-1:0] hit_word_t;

  // Assemble one hit word from its fields using the offsets above
  function automatic hit_word_t pack_hit(
    input logic [BCID_W-1:0] bcid,
    input logic              cal_err,
    input logic              toa_err,
    input logic              tot_err,
    input logic [CAL_W-1:0]  cal,
    input logic [TOA_W-1:0]  toa,
    input logic [TOT_W-1:0]  tot
  );
    hit_word_t w;
    w                          = '0;
    w[BCID_LSB +: BCID_W]      = bcid;
    w[CAL_ERR_BIT]             = cal_err;
    w[TOA_ERR_BIT]             = toa_err;
    w[TOT_ERR_BIT]             = tot_err;
    w[CAL_LSB +: CAL_W]        = cal;
    w[TOA_LSB +: TOA_W]        = toa;
    w[TOT_LSB +: TOT_W]        = tot;
    return w;
  endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// rtl/tdc_sync_fifo.sv - synchronous FIFO with registered head output, count and full/empty
module tdc_sync_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     rvalid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, count_after_pop;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q;
  logic             push_ok, pop_ok;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

  // Next-state: accept/pop decisions, pointer and count updates, and the next head word.
  // The head register is the word at rd_ptr after this edge; when the buffer is empty
  // after the pop, an accepted write becomes the head directly so it shows one cycle later.
  always_comb begin
    pop_ok          = pop_i & rvalid_q;
    push_ok         = push_i & (~full_o | pop_ok);
    wr_ptr_d        = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d        = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_after_pop = count_q - CW'(pop_ok);
    count_d         = count_after_pop + CW'(push_ok);
    rdata_d         = rdata_q;
    if (count_d != '0) begin
      if (count_after_pop == '0) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Pointers, count and registered head/valid
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= (count_d != '0);
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (rstn_i && push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/tdc_hit_buffer.sv
// rtl/tdc_hit_buffer.sv - bunch-crossing tagged hit capture into a FIFO with overflow counting
module tdc_hit_buffer
  import tdc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int BC_MAX = BC_MAX_DEFAULT
) (
  input  logic                   clk40M,
  input  logic                   rstn,
  input  logic                   bcReset,
  input  logic                   enableBuf,
  input  logic                   hitFlag,
  input  logic [TOA_W-1:0]       TOA_codeReg,
  input  logic [TOT_W-1:0]       TOT_codeReg,
  input  logic [CAL_W-1:0]       Cal_codeReg,
  input  logic                   TOAerrorFlagReg,
  input  logic                   TOTerrorFlagReg,
  input  logic                   CalerrorFlagReg,
  output logic [HIT_W-1:0]       dataOut,
  output logic                   dataValid,
  input  logic                   dataReady,
  output logic                   fifoEmpty,
  output logic                   fifoFull,
  output logic [$clog2(DEPTH):0] wordCount,
  output logic [7:0]             overflowCnt
);

  localparam logic [BCID_W-1:0] BC_LAST = BCID_W'(BC_MAX);

  logic [BCID_W-1:0] bcid_q, bcid_d;
  logic [7:0]        ovf_q, ovf_d;
  logic              capture;
  logic              pop;
  logic              drop;
  hit_word_t         hit_word;

  assign capture     = hitFlag & enableBuf;
  assign pop         = dataValid & dataReady;
  assign drop        = capture & fifoFull & ~pop;
  assign overflowCnt = ovf_q;

  // Word carries the crossing counter as it stood before this edge's update
  assign hit_word = pack_hit(bcid_q, CalerrorFlagReg, TOAerrorFlagReg, TOTerrorFlagReg,
                             Cal_codeReg, TOA_codeReg, TOT_codeReg);

  // Next crossing ID and saturating drop count
  always_comb begin
    bcid_d = bcid_q + 1'b1;
    if (bcReset || bcid_q == BC_LAST) begin
      bcid_d = '0;
    end
    ovf_d = ovf_q;
    if (drop && ovf_q != 8'hFF) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // Crossing counter and overflow counter state
  always_ff @(posedge clk40M) begin
    if (!rstn) begin
      bcid_q <= '0;
      ovf_q  <= '0;
    end else begin
      bcid_q <= bcid_d;
      ovf_q  <= ovf_d;
    end
  end

  tdc_sync_fifo #(
    .WIDTH (HIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk40M),
    .rstn_i   (rstn),
    .push_i   (capture),
    .wdata_i  (hit_word),
    .pop_i    (dataReady),
    .rdata_o  (dataOut),
    .rvalid_o (dataValid),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty),
    .count_o  (wordCount)
  );

endmodule

// File: tb/tb_tdc_hit_buffer.sv
// tb/tb_tdc_hit_buffer.sv - scoreboard bench for tdc_hit_buffer
`timescale 1ns/1ps
module tb_tdc_hit_buffer;

  localparam int DEPTH  = 16;
  localparam int BC_MAX = 3563;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk40M = 1'b0;
  logic          rstn, bcReset, enableBuf, hitFlag, dataReady;
  logic [9:0]    TOA_codeReg, Cal_codeReg;
  logic [8:0]    TOT_codeReg;
  logic          TOAerrorFlagReg, TOTerrorFlagReg, CalerrorFlagReg;
  logic [43:0]   dataOut;
  logic          dataValid, fifoEmpty, fifoFull;
  logic [CW-1:0] wordCount;
  logic [7:0]    overflowCnt;

  tdc_hit_buffer #(.DEPTH(DEPTH), .BC_MAX(BC_MAX)) dut (
    .clk40M(clk40M), .rstn(rstn), .bcReset(bcReset), .enableBuf(enableBuf),
    .hitFlag(hitFlag), .TOA_codeReg(TOA_codeReg), .TOT_codeReg(TOT_codeReg),
    .Cal_codeReg(Cal_codeReg), .TOAerrorFlagReg(TOAerrorFlagReg),
    .TOTerrorFlagReg(TOTerrorFlagReg), .CalerrorFlagReg(CalerrorFlagReg),
    .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady),
    .fifoEmpty(fifoEmpty), .fifoFull(fifoFull), .wordCount(wordCount),
    .overflowCnt(overflowCnt)
  );

  always #12.5 clk40M = ~clk40M;

  int n_cmp = 0;
  int n_err = 0;

  logic [43:0] exp_q[$];
  int          m_cnt  = 0;
  int          m_ovf  = 0;
  int          m_bcid = 0;
  bit          m_live = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [43:0] ref_word(input int bcid);
    logic [11:0] b;
    b = 12'(bcid);
    return {b, CalerrorFlagReg, TOAerrorFlagReg, TOTerrorFlagReg,
            Cal_codeReg, TOA_codeReg, TOT_codeReg};
  endfunction

  // Reference model: checks status against its own view, then predicts the coming edge
  always @(negedge clk40M) begin
    int held;
    bit popping;
    bit hit;
    if (m_live) begin
      check("wordCount",   64'(wordCount),   64'(m_cnt));
      check("dataValid",   64'(dataValid),   64'(m_cnt > 0));
      check("fifoFull",    64'(fifoFull),    64'(m_cnt == DEPTH));
      check("fifoEmpty",   64'(fifoEmpty),   64'(m_cnt == 0));
      check("overflowCnt", 64'(overflowCnt), 64'(m_ovf));
    end
    if (!rstn) begin
      exp_q.delete();
      m_cnt  = 0;
      m_ovf  = 0;
      m_bcid = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      popping = (m_cnt > 0) && dataReady;
      hit     = hitFlag && enableBuf;
      held    = m_cnt - (popping ? 1 : 0);
      if (hit) begin
        if (held < DEPTH) begin
          exp_q.push_back(ref_word(m_bcid));
          held++;
        end else if (m_ovf < 255) begin
          m_ovf++;
        end
      end
      m_cnt  = held;
      m_bcid = (bcReset || m_bcid == BC_MAX) ? 0 : m_bcid + 1;
    end
  end

  // Output monitor: the presented word must be the oldest expected one; pop on handshake
  always @(negedge clk40M) begin
    if (m_live && rstn === 1'b1 && dataValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", dataOut, $time);
      end else begin
        check("dataOut", 64'(dataOut), 64'(exp_q[0]));
        if (dataReady) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk40M);
    #1;
  endtask

  task automatic rand_fields();
    TOA_codeReg     = 10'($urandom);
    TOT_codeReg     = 9'($urandom);
    Cal_codeReg     = 10'($urandom);
    TOAerrorFlagReg = 1'($urandom);
    TOTerrorFlagReg = 1'($urandom);
    CalerrorFlagReg = 1'($urandom);
  endtask

  task automatic wait_bcid(input int target);
    int n;
    n = 0;
    while (m_bcid != target && n < 5000) begin
      tick();
      n++;
    end
    check("bcid_reached", 64'(m_bcid), 64'(target));
  endtask

  task automatic hits(input int n);
    hitFlag = 1'b1;
    for (int i = 0; i < n; i++) begin
      rand_fields();
      tick();
    end
    hitFlag = 1'b0;
  endtask

  task automatic drain();
    hitFlag   = 1'b0;
    dataReady = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    check("drained_valid", 64'(dataValid), 64'd0);
    check("drained_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    logic [43:0] single_word;
    single_word = {12'd5, 3'b000, 10'h2AA, 10'h155, 9'h0AA};
    rstn = 1'b0; bcReset = 1'b0; enableBuf = 1'b0; hitFlag = 1'b0; dataReady = 1'b0;
    TOA_codeReg = '0; TOT_codeReg = '0; Cal_codeReg = '0;
    TOAerrorFlagReg = 1'b0; TOTerrorFlagReg = 1'b0; CalerrorFlagReg = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    check("rst_dataOut",   64'(dataOut),     64'd0);
    check("rst_dataValid", 64'(dataValid),   64'd0);
    check("rst_fifoEmpty", 64'(fifoEmpty),   64'd1);
    check("rst_fifoFull",  64'(fifoFull),    64'd0);
    check("rst_wordCount", 64'(wordCount),   64'd0);
    check("rst_overflow",  64'(overflowCnt), 64'd0);

    // single hit at bcid 5
    enableBuf = 1'b1;
    dataReady = 1'b1;
    wait_bcid(5);
    TOA_codeReg = 10'h155; TOT_codeReg = 9'h0AA; Cal_codeReg = 10'h2AA;
    hitFlag = 1'b1;
    tick();
    hitFlag = 1'b0;
    check("single_valid", 64'(dataValid), 64'd1);
    check("single_word",  64'(dataOut),   64'(single_word));
    tick();
    check("single_gone",  64'(dataValid), 64'd0);

    // bcid wrap
    wait_bcid(BC_MAX);
    hitFlag = 1'b1;
    rand_fields();
    tick();
    check("wrap_first_bcid", 64'(dataOut[43:32]), 64'd3563);
    rand_fields();
    tick();
    hitFlag = 1'b0;
    check("wrap_second_bcid", 64'(dataOut[43:32]), 64'd0);
    drain();

    // overflow with 20 hits, then full push+pop, then readout
    dataReady = 1'b0;
    hits(20);
    check("ovf_full",  64'(fifoFull),    64'd1);
    check("ovf_count", 64'(wordCount),   64'd16);
    check("ovf_drops", 64'(overflowCnt), 64'd4);
    dataReady = 1'b1;
    hits(1);
    check("pp_count", 64'(wordCount),   64'd16);
    check("pp_drops", 64'(overflowCnt), 64'd4);
    drain();

    // backpressure with three words
    dataReady = 1'b0;
    hits(3);
    for (int i = 0; i < 20; i++) begin
      dataReady = 1'($urandom);
      tick();
    end
    drain();

    // reset mid-operation with 8 words held and 3 drops
    do_reset();
    dataReady = 1'b0;
    hits(19);
    dataReady = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    dataReady = 1'b0;
    check("mid_count", 64'(wordCount),   64'd8);
    check("mid_drops", 64'(overflowCnt), 64'd3);
    rstn    = 1'b0;
    hitFlag = 1'b1;
    tick();
    rstn    = 1'b1;
    hitFlag = 1'b0;
    check("mid_rst_count", 64'(wordCount),   64'd0);
    check("mid_rst_valid", 64'(dataValid),   64'd0);
    check("mid_rst_drops", 64'(overflowCnt), 64'd0);
    hits(1);
    check("mid_rst_bcid",  64'(dataOut[43:32]), 64'd0);
    check("mid_rst_one",   64'(wordCount),      64'd1);
    drain();

    // disabled hits ignored while full, then saturation
    dataReady = 1'b0;
    hits(DEPTH);
    enableBuf = 1'b0;
    hits(10);
    check("disabled_drops", 64'(overflowCnt), 64'd0);
    enableBuf = 1'b1;
    hits(300);
    check("saturated", 64'(overflowCnt), 64'd255);
    drain();
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      hitFlag   = ($urandom_range(0, 1) == 1);
      enableBuf = ($urandom_range(0, 4) != 0);
      dataReady = ($urandom_range(0, 4) < 3);
      bcReset   = ($urandom_range(0, 99) == 0);
      rand_fields();
      tick();
    end
    bcReset   = 1'b0;
    enableBuf = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_hit_buffer.md
TDC_HIT_BUFFER -- requirements
Module: tdc_hit_buffer

Interface
REQ-001 The parameter list SHALL be: DEPTH, 16, number of hit-word entries (power of two, 4..64).
REQ-002 The parameter list SHALL also include: BC_MAX, 3563, last bunch-crossing ID before wrap.
REQ-003 The ports SHALL be as follows.
- clk40M  in  1  sole clock; all logic on its rising edge.
- rstn  in  1  reset, synchronous, active-low.
- bcReset  in  1  bunch-crossing counter reset.
- enableBuf  in  1  hit capture enable.
- hitFlag  in  1  encoder hit flag for the current crossing.
- TOA_codeReg  in  10  encoded TOA.
- TOT_codeReg  in  9  encoded TOT.
- Cal_codeReg  in  10  encoded calibration code.
- TOAerrorFlagReg, TOTerrorFlagReg, CalerrorFlagReg  in  1 each  encoder error flags.
- dataOut  out  44  hit word.
- dataValid  out  1  dataOut is valid.
- dataReady  in  1  consumer accepts dataOut.
- fifoEmpty, fifoFull  out  1 each  buffer status.
- wordCount  out  clog2(DEPTH)+1  number of words held.
- overflowCnt  out  8  number of dropped hits.

Function
REQ-004 A 12-bit bcid counter SHALL increment every cycle and wrap from BC_MAX to 0.
REQ-005 bcReset=1 SHALL load bcid=0 on the next edge and SHALL take priority over increment and wrap.
REQ-006 A hit SHALL be captured on an edge where hitFlag=1 and enableBuf=1; with enableBuf=0, hits SHALL be ignored and overflowCnt SHALL be unaffected.
REQ-007 The hit word SHALL be {bcid[11:0], CalerrorFlagReg, TOAerrorFlagReg, TOTerrorFlagReg, Cal_codeReg, TOA_codeReg, TOT_codeReg}, MSB to LSB, 44 bits.
REQ-008 The bcid stored in a hit word SHALL be the counter value before that edge's update.
REQ-009 The buffer SHALL be strictly FIFO-ordered.
REQ-010 There SHALL be no fall-through: a word captured into an empty buffer SHALL appear on dataOut with dataValid=1 exactly one cycle after capture.
REQ-011 dataOut and dataValid SHALL be registered outputs.
REQ-012 A pop SHALL occur when dataValid=1 and dataReady=1 on the same edge.
REQ-013 While dataValid=1 and dataReady=0, dataOut SHALL remain stable.
REQ-014 dataValid SHALL be 1 exactly when wordCount>0.
REQ-015 A simultaneous push and pop SHALL leave wordCount unchanged, and both operations SHALL take effect.
REQ-016 When the buffer is full, a push coinciding with a pop SHALL be accepted, with no drop.
REQ-017 When the buffer is full, a push without a pop SHALL be dropped, overflowCnt SHALL increment, and buffer contents SHALL be unchanged.
REQ-018 overflowCnt SHALL saturate at 255.
REQ-019 When the buffer is empty, a pop SHALL be impossible (dataValid=0), and dataReady SHALL be ignored.
REQ-020 fifoFull SHALL equal (wordCount==DEPTH).
REQ-021 fifoEmpty SHALL equal (wordCount==0).
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-023 When rstn=0 at an edge, the block SHALL set bcid=0, pointers=0, wordCount=0, dataValid=0, dataOut=0, overflowCnt=0, fifoEmpty=1 and fifoFull=0.
REQ-024 Reset SHALL take priority over bcReset, push and pop.
REQ-025 Reset asserted mid-operation SHALL discard all buffered words.
REQ-026 A hit presented on the same edge as reset SHALL be lost.
REQ-027 Storage RAM contents SHALL need no reset.

Structure
REQ-028 A shared package tdc_pkg SHALL hold HIT_W=44, BCID_W=12, the default BC_MAX value and the hit-word field offsets.
REQ-029 The storage and pointer logic SHALL be in one sub-module, tdc_sync_fifo, parameterised by width and depth, containing registered output, count and full/empty logic.
REQ-030 The top level SHALL hold the bcid counter, word assembly, the overflow counter and the capture gating.

Verification
REQ-031 The bench SHALL run a single-hit test: reset release, bcid=5, hitFlag=1, TOA=0x155, TOT=0x0AA, Cal=0x2AA, flags 0, dataReady=1 -> next cycle dataValid=1 and dataOut={12'd5,3'b000,10'h2AA,10'h155,9'h0AA}, then dataValid=0.
REQ-032 The bench SHALL run a bcid wrap test: run to bcid=3563 and capture a hit there, then a hit the next cycle -> stored bcids 3563 and 0.
REQ-033 The bench SHALL run an overflow test: dataReady=0 with 20 consecutive hits at DEPTH=16 -> fifoFull=1, wordCount=16, overflowCnt=4, and readout returns the first 16 hits in order.
REQ-034 The bench SHALL run a full push+pop test: with the buffer full and dataReady=1, hitFlag=1 -> wordCount stays 16, overflowCnt unchanged, and the new hit is last out.
REQ-035 The bench SHALL run a backpressure test: 3 words buffered, dataReady toggled 0/1 -> dataOut stable while dataReady=0, and 3 pops in order.
REQ-036 The bench SHALL run a reset-mid-operation test: 8 words buffered and overflowCnt=3, then rstn=0 for one edge -> wordCount=0, dataValid=0, overflowCnt=0, bcid=0.
